// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared widths, access-size and FSM state encodings and small
// helpers for the load/store control unit.
package lsu_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int MASKW = XLEN / 8;

  // Access size as carried on agu_cmd_size.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } lsu_size_e;

  // One transaction walks IDLE -> REQ -> WAIT -> DONE, or IDLE -> DONE on error.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  // Command as held for the lifetime of one transaction.
  typedef struct packed {
    logic             read;
    logic             usign;
    lsu_size_e        size;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [MASKW-1:0] wmask;
  } lsu_cmd_t;

  // The data bus only sees word addresses.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_ctrl_ld_align.sv
// lsu_ctrl_ld_align: picks the addressed byte/halfword out of a loaded word
// and sign- or zero-extends it. Halfwords use addr[1] only, so a halfword at
// addr[0]=1 returns bits of the shifted word and never wraps into the next word.
module lsu_ctrl_ld_align
  import lsu_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  lsu_size_e       size_i,
  input  logic            usign_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] byte_shifted;
  logic [XLEN-1:0] half_shifted;
  logic            byte_fill;
  logic            half_fill;

  assign byte_shifted = rdata_i >> {addr_lo_i, 3'b000};
  assign half_shifted = rdata_i >> {addr_lo_i[1], 4'b0000};
  assign byte_fill    = ~usign_i & byte_shifted[7];
  assign half_fill    = ~usign_i & half_shifted[15];

  // Select and extend according to access size; word (and reserved) pass through.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    result_o = rdata_i;
    unique case (size_i)
      SIZE_BYTE: result_o = {{(XLEN-8){byte_fill}}, byte_shifted[7:0]};
      SIZE_HALF: result_o = {{(XLEN-16){half_fill}}, half_shifted[15:0]};
      default:   result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control unit. Takes one command from the AGU, runs a
// single-outstanding valid/ready data-bus transaction and returns the aligned
// load result (or an error) to writeback as a one-cycle strobe.
// Optional feature: define LSU_MISALGN_TRAP_EN to turn agu_cmd_misalgn into an
// error without bus access; otherwise misalignment is ignored.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  // command from address generation
  input  logic             agu_cmd_enable,
  output logic             agu_cmd_ready,
  input  logic             agu_cmd_read,
  input  logic             agu_cmd_write,
  input  logic             agu_cmd_usign,
  input  logic [1:0]       agu_cmd_size,
  input  logic [XLEN-1:0]  agu_cmd_addr,
  input  logic [XLEN-1:0]  agu_cmd_wdata,
  input  logic [MASKW-1:0] agu_cmd_wmask,
  input  logic             agu_cmd_misalgn,
  // data bus
  output logic             dbus_cmd_valid,
  input  logic             dbus_cmd_ready,
  output logic             dbus_cmd_read,
  output logic [XLEN-1:0]  dbus_cmd_addr,
  output logic [XLEN-1:0]  dbus_cmd_wdata,
  output logic [MASKW-1:0] dbus_cmd_wmask,
  input  logic             dbus_rsp_valid,
  input  logic [XLEN-1:0]  dbus_rsp_rdata,
  input  logic             dbus_rsp_err,
  // writeback
  output logic             memtop_wback_valid,
  output logic [XLEN-1:0]  memtop_wback_data,
  output logic             memtop_wback_err
);

  lsu_state_e      state_q, state_d;
  lsu_cmd_t        cmd_q, cmd_d;
  logic            cap_en;
  logic            wb_load;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_err_q, wb_err_d;
  logic [XLEN-1:0] ld_result;
  logic            misalgn_trap;
  logic            cmd_start;
  logic            cmd_err;

`ifdef LSU_MISALGN_TRAP_EN
  assign misalgn_trap = agu_cmd_misalgn;
`else
  logic unused_misalgn;
  assign unused_misalgn = agu_cmd_misalgn;
  assign misalgn_trap   = 1'b0;
`endif

  // A command with neither direction set is not a transaction and is ignored.
  assign cmd_start = agu_cmd_enable & (agu_cmd_read | agu_cmd_write);
  assign cmd_err   = (lsu_size_e'(agu_cmd_size) == SIZE_RSVD)
                   | (agu_cmd_read & agu_cmd_write)
                   | misalgn_trap;

  // Stores carry their byte enables; loads always present an empty mask.
  always_comb begin
    cmd_d.read  = agu_cmd_read;
    cmd_d.usign = agu_cmd_usign;
    cmd_d.size  = lsu_size_e'(agu_cmd_size);
    cmd_d.addr  = agu_cmd_addr;
    cmd_d.wdata = agu_cmd_wdata;
    cmd_d.wmask = agu_cmd_read ? '0 : agu_cmd_wmask;
  end

  lsu_ctrl_ld_align u_ld_align (
    .rdata_i   (dbus_rsp_rdata),
    .addr_lo_i (cmd_q.addr[1:0]),
    .size_i    (cmd_q.size),
    .usign_i   (cmd_q.usign),
    .result_o  (ld_result)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake outputs and writeback load strobes.
  always_comb begin
    state_d            = state_q;
    cap_en             = 1'b0;
    wb_load            = 1'b0;
    wb_data_d          = '0;
    wb_err_d           = 1'b0;
    agu_cmd_ready      = 1'b0;
    dbus_cmd_valid     = 1'b0;
    memtop_wback_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        agu_cmd_ready = 1'b1;
        if (cmd_start) begin
          cap_en = 1'b1;
          if (cmd_err) begin
            wb_load  = 1'b1;
            wb_err_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        dbus_cmd_valid = 1'b1;
        if (dbus_cmd_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dbus_rsp_valid) begin
          wb_load   = 1'b1;
          wb_err_d  = dbus_rsp_err;
          wb_data_d = (cmd_q.read && !dbus_rsp_err) ? ld_result : '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        memtop_wback_valid = 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture and writeback result registers.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well so bus and writeback outputs read 0 out of reset.
    if (rst) begin
      cmd_q     <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      if (cap_en) begin
        cmd_q <= cmd_d;
      end
      if (wb_load) begin
        wb_data_q <= wb_data_d;
        wb_err_q  <= wb_err_d;
      end
    end
  end

  assign dbus_cmd_read     = cmd_q.read;
  assign dbus_cmd_addr     = word_addr(cmd_q.addr);
  assign dbus_cmd_wdata    = cmd_q.wdata;
  assign dbus_cmd_wmask    = cmd_q.wmask;
  assign memtop_wback_data = wb_data_q;
  assign memtop_wback_err  = wb_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl with a small bus
// responder (programmable ready stall, one-cycle response latency).
`timescale 1ns/1ps
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        agu_cmd_enable, agu_cmd_ready, agu_cmd_read, agu_cmd_write;
  logic        agu_cmd_usign, agu_cmd_misalgn;
  logic [1:0]  agu_cmd_size;
  logic [31:0] agu_cmd_addr, agu_cmd_wdata;
  logic [3:0]  agu_cmd_wmask;
  logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_read;
  logic [31:0] dbus_cmd_addr, dbus_cmd_wdata;
  logic [3:0]  dbus_cmd_wmask;
  logic        dbus_rsp_valid, dbus_rsp_err;
  logic [31:0] dbus_rsp_rdata;
  logic        memtop_wback_valid, memtop_wback_err;
  logic [31:0] memtop_wback_data;

  int total = 0;
  int bad   = 0;

  // results of the last txn() call
  int          r_lat, r_bus;
  logic [31:0] r_addr, r_wdata, r_data;
  logic [3:0]  r_wmask;
  logic        r_read, r_drop, r_rdy_bad, r_rdy_back, r_err;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .agu_cmd_enable     (agu_cmd_enable),
    .agu_cmd_ready      (agu_cmd_ready),
    .agu_cmd_read       (agu_cmd_read),
    .agu_cmd_write      (agu_cmd_write),
    .agu_cmd_usign      (agu_cmd_usign),
    .agu_cmd_size       (agu_cmd_size),
    .agu_cmd_addr       (agu_cmd_addr),
    .agu_cmd_wdata      (agu_cmd_wdata),
    .agu_cmd_wmask      (agu_cmd_wmask),
    .agu_cmd_misalgn    (agu_cmd_misalgn),
    .dbus_cmd_valid     (dbus_cmd_valid),
    .dbus_cmd_ready     (dbus_cmd_ready),
    .dbus_cmd_read      (dbus_cmd_read),
    .dbus_cmd_addr      (dbus_cmd_addr),
    .dbus_cmd_wdata     (dbus_cmd_wdata),
    .dbus_cmd_wmask     (dbus_cmd_wmask),
    .dbus_rsp_valid     (dbus_rsp_valid),
    .dbus_rsp_rdata     (dbus_rsp_rdata),
    .dbus_rsp_err       (dbus_rsp_err),
    .memtop_wback_valid (memtop_wback_valid),
    .memtop_wback_data  (memtop_wback_data),
    .memtop_wback_err   (memtop_wback_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one command (accepted at edge N) and play the bus: ready after
  // 'stall' valid cycles, response in the cycle following the handshake.
  // r_lat is the cycle (N+k) in which wback_valid is seen, -1 on timeout.
  task automatic txn(input logic rd, input logic wr, input logic us,
                     input logic [1:0] sz, input logic [31:0] ad,
                     input logic [31:0] wd, input logic [3:0] wm,
                     input logic mis, input int stall,
                     input logic [31:0] rdat, input logic rerr);
    int   vcnt;
    int   hs_k;
    logic rsp_now;
    @(negedge clk);
    agu_cmd_enable  = 1'b1;
    agu_cmd_read    = rd;
    agu_cmd_write   = wr;
    agu_cmd_usign   = us;
    agu_cmd_size    = sz;
    agu_cmd_addr    = ad;
    agu_cmd_wdata   = wd;
    agu_cmd_wmask   = wm;
    agu_cmd_misalgn = mis;
    r_lat = -1; r_bus = 0; r_addr = '0; r_wdata = '0; r_wmask = '0; r_read = 1'b0;
    r_drop = 1'b0; r_rdy_bad = 1'b0; r_rdy_back = 1'b0; r_data = '0; r_err = 1'b0;
    vcnt = 0;
    hs_k = -100;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      agu_cmd_enable = 1'b0;
      if (agu_cmd_ready) r_rdy_bad = 1'b1;
      if (memtop_wback_valid) begin
        r_lat = k;
        r_data = memtop_wback_data;
        r_err  = memtop_wback_err;
        break;
      end
      rsp_now = (hs_k == k - 1);
      if (dbus_cmd_valid) begin
        vcnt++;
        if (vcnt > stall) begin
          dbus_cmd_ready = 1'b1;
          r_bus++;
          r_addr  = dbus_cmd_addr;
          r_wdata = dbus_cmd_wdata;
          r_wmask = dbus_cmd_wmask;
          r_read  = dbus_cmd_read;
          hs_k    = k;
        end else begin
          dbus_cmd_ready = 1'b0;
        end
      end else begin
        dbus_cmd_ready = 1'b0;
        if (vcnt > 0 && hs_k < 0) r_drop = 1'b1;
      end
      dbus_rsp_valid = rsp_now;
      dbus_rsp_rdata = rsp_now ? rdat : 32'h0;
      dbus_rsp_err   = rsp_now & rerr;
    end
    dbus_cmd_ready = 1'b0;
    dbus_rsp_valid = 1'b0;
    dbus_rsp_rdata = 32'h0;
    dbus_rsp_err   = 1'b0;
    @(negedge clk);
    r_rdy_back = agu_cmd_ready;
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        us;
    logic [31:0] ad;
    logic [31:0] rd;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab[4];
  logic    stray;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    agu_cmd_enable = 0; agu_cmd_read = 0; agu_cmd_write = 0; agu_cmd_usign = 0;
    agu_cmd_size = 0; agu_cmd_addr = 0; agu_cmd_wdata = 0; agu_cmd_wmask = 0;
    agu_cmd_misalgn = 0;
    dbus_cmd_ready = 0; dbus_rsp_valid = 0; dbus_rsp_rdata = 0; dbus_rsp_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  {31'b0, agu_cmd_ready}, 32'd1);
    check("rst_dvalid", {31'b0, dbus_cmd_valid}, 32'd0);
    check("rst_wbv",    {31'b0, memtop_wback_valid}, 32'd0);
    check("rst_wbdata", memtop_wback_data, 32'h0);
    check("rst_wberr",  {31'b0, memtop_wback_err}, 32'd0);
    check("rst_daddr",  dbus_cmd_addr, 32'h0);
    rst = 1'b0;

    // signed byte load, zero-wait bus
    txn(1, 0, 0, 2'b00, 32'h1003, 32'h0, 4'h0, 0, 0, 32'h80AA5511, 0);
    check("lb_data",  r_data, 32'hFFFFFF80);
    check("lb_err",   {31'b0, r_err}, 32'd0);
    check("lb_lat",   r_lat, 32'd3);
    check("lb_bus",   r_bus, 32'd1);
    check("lb_addr",  r_addr, 32'h1000);
    check("lb_read",  {31'b0, r_read}, 32'd1);
    check("lb_wmask", {28'b0, r_wmask}, 32'h0);
    check("lb_rdy",   {30'b0, r_rdy_bad, r_rdy_back}, 32'd1);
    repeat (2) @(negedge clk);
    check("lb_hold",  memtop_wback_data, 32'hFFFFFF80);

    // unsigned half load with 3 cycles of ready stall
    txn(1, 0, 1, 2'b01, 32'h2002, 32'h0, 4'h0, 0, 3, 32'hBEEF1234, 0);
    check("lhu_data", r_data, 32'h0000BEEF);
    check("lhu_lat",  r_lat, 32'd6);
    check("lhu_drop", {31'b0, r_drop}, 32'd0);
    check("lhu_bus",  r_bus, 32'd1);

    // store word
    txn(0, 1, 0, 2'b10, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h12345678, 0);
    check("sw_bus",   r_bus, 32'd1);
    check("sw_read",  {31'b0, r_read}, 32'd0);
    check("sw_addr",  r_addr, 32'h10);
    check("sw_wdata", r_wdata, 32'hDEADBEEF);
    check("sw_wmask", {28'b0, r_wmask}, 32'hF);
    check("sw_data",  r_data, 32'h0);
    check("sw_err",   {31'b0, r_err}, 32'd0);
    check("sw_lat",   r_lat, 32'd3);

    // misaligned word load
    txn(1, 0, 0, 2'b10, 32'h1001, 32'h0, 4'h0, 1, 0, 32'h11223344, 0);
`ifdef LSU_MISALGN_TRAP_EN
    check("mis_err",  {31'b0, r_err}, 32'd1);
    check("mis_lat",  r_lat, 32'd1);
    check("mis_bus",  r_bus, 32'd0);
    check("mis_data", r_data, 32'h0);
`else
    check("mis_err",  {31'b0, r_err}, 32'd0);
    check("mis_lat",  r_lat, 32'd3);
    check("mis_addr", r_addr, 32'h1000);
    check("mis_data", r_data, 32'h11223344);
`endif

    // bus error on load
    txn(1, 0, 0, 2'b10, 32'h40, 32'h0, 4'h0, 0, 0, 32'hCAFEF00D, 1);
    check("berr_err",  {31'b0, r_err}, 32'd1);
    check("berr_data", r_data, 32'h0);
    check("berr_lat",  r_lat, 32'd3);

    // reserved size
    txn(1, 0, 0, 2'b11, 32'h80, 32'h0, 4'h0, 0, 0, 32'h55555555, 0);
    check("rsvd_err", {31'b0, r_err}, 32'd1);
    check("rsvd_lat", r_lat, 32'd1);
    check("rsvd_bus", r_bus, 32'd0);
    check("rsvd_rdy", {31'b0, r_rdy_back}, 32'd1);

    // read and write both set
    txn(1, 1, 0, 2'b10, 32'h84, 32'h0, 4'hF, 0, 0, 32'h0, 0);
    check("rw_err", {31'b0, r_err}, 32'd1);
    check("rw_lat", r_lat, 32'd1);
    check("rw_bus", r_bus, 32'd0);

    // extraction table
    ld_tab[0] = '{2'b00, 1'b1, 32'h0001, 32'h80AA5511, 32'h00000055};
    ld_tab[1] = '{2'b00, 1'b1, 32'h0003, 32'h80AA5511, 32'h00000080};
    ld_tab[2] = '{2'b01, 1'b0, 32'h0000, 32'h12348001, 32'hFFFF8001};
    ld_tab[3] = '{2'b01, 1'b0, 32'h0002, 32'h7FFF0000, 32'h00007FFF};
    foreach (ld_tab[i]) begin
      txn(1, 0, ld_tab[i].us, ld_tab[i].sz, ld_tab[i].ad, 32'h0, 4'h0, 0, 0,
          ld_tab[i].rd, 0);
      check($sformatf("ext%0d_data", i), r_data, ld_tab[i].exp);
      check($sformatf("ext%0d_lat", i), r_lat, 32'd3);
    end

    // enable with neither read nor write is ignored
    @(negedge clk);
    agu_cmd_enable = 1'b1; agu_cmd_read = 1'b0; agu_cmd_write = 1'b0;
    @(negedge clk);
    agu_cmd_enable = 1'b0;
    check("nop_ready",  {31'b0, agu_cmd_ready}, 32'd1);
    check("nop_dvalid", {31'b0, dbus_cmd_valid}, 32'd0);

    // reset while waiting for the response
    @(negedge clk);
    agu_cmd_enable = 1'b1; agu_cmd_read = 1'b1; agu_cmd_size = 2'b10;
    agu_cmd_addr = 32'h300; agu_cmd_misalgn = 1'b0;
    @(negedge clk);
    agu_cmd_enable = 1'b0;
    check("rstw_dvalid", {31'b0, dbus_cmd_valid}, 32'd1);
    dbus_cmd_ready = 1'b1;
    @(negedge clk);
    dbus_cmd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_ready",  {31'b0, agu_cmd_ready}, 32'd1);
    check("rstw_wbv",    {31'b0, memtop_wback_valid}, 32'd0);
    check("rstw_dvalid2", {31'b0, dbus_cmd_valid}, 32'd0);
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (memtop_wback_valid) stray = 1'b1;
    end
    check("rstw_nowb", {31'b0, stray}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
